// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the Hack core execution controller.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    RST  = 2'd0,
    HALT = 2'd1,
    RUN  = 2'd2,
    STEP = 2'd3
  } run_state_t;

  localparam int BTN_RUN  = 0;
  localparam int BTN_STEP = 1;
  localparam int BTN_RST  = 2;

endpackage

// File: rtl/btn_debounce.sv
// One push button: 2-flop synchronizer, stability down-counter, and a
// single-cycle pulse on the accepted released->pressed transition.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_n,
  output logic press_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic             pressed_q, pressed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             raw_pressed;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= 2'b11;
      pressed_q <= 1'b0;
      cnt_q     <= CNT_LOAD;
      pulse_q   <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      pressed_q <= pressed_d;
      cnt_q     <= cnt_d;
      pulse_q   <= pulse_d;
    end
  end

  // Counter reloads whenever the level agrees with the accepted one, so any
  // bounce restarts the stability window.
  always_comb begin
    sync_d      = {sync_q[0], btn_n};
    raw_pressed = ~sync_q[1];
    pressed_d   = pressed_q;
    cnt_d       = CNT_LOAD;
    pulse_d     = 1'b0;
    if (raw_pressed != pressed_q) begin
      if (cnt_q == '0) begin
        pressed_d = raw_pressed;
        pulse_d   = raw_pressed;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  assign press_pulse = pulse_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt/step/reset controller for the Hack core: gates the core clock
// enable, stops on a PC breakpoint and counts executed instructions.
//
// state | meaning
// RST   | core held in reset for RESET_CYCLES cycles
// HALT  | core stopped, waiting for run or step
// RUN   | core free-running until run press or breakpoint
// STEP  | core executes exactly one instruction
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RESET_CYCLES    = 4,
  parameter int PC_W            = 15
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [2:0]      btn_n,
  input  logic            bp_en,
  input  logic [PC_W-1:0] bp_addr,
  input  logic [PC_W-1:0] debug_pc,
  output logic            cpu_en,
  output logic            cpu_reset,
  output logic [1:0]      state_o,
  output logic            bp_hit,
  output logic [15:0]     instr_count
);

  localparam int RC_W = $clog2(RESET_CYCLES + 1);
  localparam logic [RC_W-1:0] RST_LOAD = RC_W'(RESET_CYCLES - 1);

  logic [2:0]      pulse;
  run_state_t      state_q, state_d;
  logic [RC_W-1:0] rst_cnt_q, rst_cnt_d;
  logic            skip_bp_q, skip_bp_d;
  logic            bp_hit_q, bp_hit_d;
  logic [15:0]     instr_count_q, instr_count_d;
  logic            cpu_reset_q, cpu_reset_d;
  logic            rst_cmd, step_cmd, run_cmd;
  logic            bp_stop;

  for (genvar i = 0; i < 3; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk        (clk),
      .reset_n    (reset_n),
      .btn_n      (btn_n[i]),
      .press_pulse(pulse[i])
    );
  end

  assign rst_cmd  = pulse[BTN_RST];
  assign step_cmd = pulse[BTN_STEP] & ~rst_cmd;
  assign run_cmd  = pulse[BTN_RUN] & ~pulse[BTN_STEP] & ~rst_cmd;
  assign bp_stop  = bp_en && (debug_pc == bp_addr) && !skip_bp_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= RST;
      rst_cnt_q     <= RST_LOAD;
      skip_bp_q     <= 1'b0;
      bp_hit_q      <= 1'b0;
      instr_count_q <= 16'h0000;
      cpu_reset_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      skip_bp_q     <= skip_bp_d;
      bp_hit_q      <= bp_hit_d;
      instr_count_q <= instr_count_d;
      cpu_reset_q   <= cpu_reset_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    skip_bp_d = skip_bp_q;
    if (rst_cmd) begin
      state_d   = RST;
      rst_cnt_d = RST_LOAD;
    end else begin
      case (state_q)
        RST: begin
          if (rst_cnt_q == '0) state_d = HALT;
          else                 rst_cnt_d = rst_cnt_q - 1'b1;
        end
        HALT: begin
          if (step_cmd) begin
            state_d = STEP;
          end else if (run_cmd) begin
            state_d   = RUN;
            skip_bp_d = 1'b1;
          end
        end
        RUN: begin
          skip_bp_d = 1'b0;
          if (run_cmd || bp_stop) state_d = HALT;
        end
        STEP:    state_d = HALT;
        default: state_d = RST;
      endcase
    end
  end

  // cpu_en stays combinational so a matching PC is never clocked into the core.
  always_comb begin
    cpu_en = 1'b0;
    case (state_q)
      RUN:     cpu_en = !bp_stop && !run_cmd && !rst_cmd;
      STEP:    cpu_en = !rst_cmd;
      default: cpu_en = 1'b0;
    endcase

    bp_hit_d = bp_hit_q;
    if (state_d == RST || pulse[BTN_RUN] || pulse[BTN_STEP]) bp_hit_d = 1'b0;
    else if (state_q == RUN && bp_stop)                       bp_hit_d = 1'b1;

    instr_count_d = (state_d == RST) ? 16'h0000 : instr_count_q + {15'h0000, cpu_en};
    cpu_reset_d   = (state_d == RST);
  end

  assign cpu_reset   = cpu_reset_q;
  assign state_o     = state_q;
  assign bp_hit      = bp_hit_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: a core model advances the PC on cpu_en,
// stimulus pushes the expected state transitions, a monitor checks them.
module tb_cpu_run_ctrl;

  localparam int S_RST = 0, S_HALT = 1, S_RUN = 2, S_STEP = 3;
  localparam int RESET_CYCLES = 4;

  logic        clk;
  logic        reset_n;
  logic [2:0]  btn_n;
  logic        bp_en;
  logic [14:0] bp_addr;
  logic [14:0] debug_pc;
  logic        cpu_en;
  logic        cpu_reset;
  logic [1:0]  state_o;
  logic        bp_hit;
  logic [15:0] instr_count;

  cpu_run_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .RESET_CYCLES   (RESET_CYCLES),
    .PC_W           (15)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_n      (btn_n),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .debug_pc   (debug_pc),
    .cpu_en     (cpu_en),
    .cpu_reset  (cpu_reset),
    .state_o    (state_o),
    .bp_hit     (bp_hit),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int st;
    int cnt;     // -1: only checked against the core model
    int bp;
    int pc;      // -1: not checked
    bit chk_en;  // cpu_en must have been low in the last RUN cycle
    bit chk_rst; // cpu_reset must have been high RESET_CYCLES cycles
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int passed = 0;
  int core_cnt = 0;
  logic [14:0] core_pc_n = '0;
  int m_cnt = 0;
  int m_pc = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  function automatic exp_t mk(int st, int cnt, int bp, int pc, bit ce, bit cr);
    exp_t e;
    e.st = st; e.cnt = cnt; e.bp = bp; e.pc = pc; e.chk_en = ce; e.chk_rst = cr;
    return e;
  endfunction

  // Monitor and core model
  initial begin
    logic [1:0] prev_st;
    logic prev_en;
    int rst_len;
    exp_t e;
    prev_st = 2'd0;
    prev_en = 1'b0;
    rst_len = 0;
    forever begin
      @(negedge clk);
      if (state_o !== prev_st) begin
        if (sb.size() == 0) begin
          chk("unexpected_transition", state_o, prev_st);
        end else begin
          e = sb.pop_front();
          chk("state", state_o, e.st);
          if (e.cnt >= 0) chk("instr_count", instr_count, e.cnt & 16'hFFFF);
          if (e.st != S_RST) chk("count_vs_core", instr_count, core_cnt & 16'hFFFF);
          chk("bp_hit", bp_hit, e.bp);
          if (e.pc >= 0) chk("halt_pc", debug_pc, e.pc);
          if (e.chk_en) chk("en_low_last_run_cycle", prev_en, 0);
          if (e.chk_rst) chk("cpu_reset_len", rst_len, RESET_CYCLES);
        end
      end
      if (!reset_n || !cpu_reset) rst_len = 0;
      else rst_len++;
      if (cpu_reset) begin
        core_pc_n = '0;
        core_cnt  = 0;
      end else if (cpu_en) begin
        core_pc_n = debug_pc + 15'd1;
        core_cnt++;
      end else begin
        core_pc_n = debug_pc;
      end
      prev_en = cpu_en;
      prev_st = state_o;
    end
  end

  initial begin
    debug_pc = '0;
    forever begin
      @(posedge clk);
      #1 debug_pc = core_pc_n;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, %0d/%0d", passed, total);
    $fatal(1);
  end

  task automatic press(input logic [2:0] mask, input int hold, input int nb);
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      btn_n = (i % 2 == 0) ? ~mask : 3'b111;
    end
    @(negedge clk);
    btn_n = ~mask;
    repeat (hold) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      btn_n = (i % 2 == 0) ? 3'b111 : ~mask;
    end
    @(negedge clk);
    btn_n = 3'b111;
    repeat (12) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    sb.delete();
  endtask

  task automatic do_step(input int nb);
    sb.push_back(mk(S_STEP, m_cnt, 0, -1, 0, 0));
    m_cnt++;
    m_pc = (m_pc + 1) % 32768;
    sb.push_back(mk(S_HALT, m_cnt, 0, m_pc, 0, 0));
    press(3'b010, 10, nb);
    wait_idle(60);
  endtask

  task automatic run_to_bp(input int a);
    bp_en   = 1'b1;
    bp_addr = 15'(a);
    sb.push_back(mk(S_RUN, m_cnt, 0, -1, 0, 0));
    m_cnt += a - m_pc;
    m_pc = a;
    sb.push_back(mk(S_HALT, m_cnt, 1, a, 1, 0));
    press(3'b001, 10 + $urandom_range(0, 5), $urandom_range(0, 4));
    wait_idle(80);
  endtask

  task automatic free_run(input int cycles);
    sb.push_back(mk(S_RUN, m_cnt, 0, -1, 0, 0));
    press(3'b001, 10 + $urandom_range(0, 5), $urandom_range(0, 4));
    repeat (cycles) @(negedge clk);
    sb.push_back(mk(S_HALT, -1, 0, -1, 1, 0));
    press(3'b001, 10 + $urandom_range(0, 5), $urandom_range(0, 4));
    wait_idle(80);
    m_cnt = core_cnt;
    m_pc  = int'(debug_pc);
  endtask

  initial begin
    reset_n = 1'b0;
    btn_n   = 3'b111;
    bp_en   = 1'b0;
    bp_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_state", state_o, S_RST);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_cpu_en", cpu_en, 0);
    chk("rst_bp_hit", bp_hit, 0);
    chk("rst_instr_count", instr_count, 0);

    sb.push_back(mk(S_HALT, 0, 0, 0, 0, 1));
    @(posedge clk);
    #1 reset_n = 1'b1;
    wait_idle(40);
    chk("halt_cpu_en", cpu_en, 0);

    do_step(4);
    run_to_bp(5);
    chk("bp_count_is_5", instr_count, 5);

    free_run(15);
    chk("resumed_past_bp", int'(debug_pc > 15'd5), 1);

    bp_en = 1'b0;
    for (int r = 0; r < 6; r++) begin
      case ($urandom_range(0, 2))
        0: begin
          int n;
          n = $urandom_range(1, 3);
          for (int k = 0; k < n; k++) do_step($urandom_range(0, 4));
        end
        1: run_to_bp(m_pc + $urandom_range(1, 12));
        default: begin
          bp_en = 1'b0;
          free_run($urandom_range(3, 30));
        end
      endcase
    end

    // reset and run pressed together while running: reset wins
    bp_en = 1'b0;
    sb.push_back(mk(S_RUN, m_cnt, 0, -1, 0, 0));
    press(3'b001, 12, 2);
    repeat (5) @(negedge clk);
    sb.push_back(mk(S_RST, 0, 0, -1, 0, 0));
    sb.push_back(mk(S_HALT, 0, 0, 0, 0, 1));
    press(3'b101, 12, 3);
    wait_idle(60);
    m_cnt = 0;
    m_pc  = 0;

    // wrap: preload the counter just below rollover, then execute 3
    @(negedge clk);
    #1;
    force dut.instr_count_q = 16'hFFFE;
    core_cnt = 32'hFFFE;
    m_cnt    = 32'hFFFE;
    @(posedge clk);
    #1 release dut.instr_count_q;
    run_to_bp(3);
    chk("wrap_count", instr_count, 1);

    // async reset while running
    bp_en = 1'b0;
    sb.push_back(mk(S_RUN, m_cnt, 0, -1, 0, 0));
    press(3'b001, 12, 1);
    repeat (5) @(negedge clk);
    chk("running_before_async", cpu_en, 1);
    #2;
    sb.push_back(mk(S_RST, 0, 0, -1, 0, 0));
    reset_n = 1'b0;
    #1;
    chk("async_cpu_en", cpu_en, 0);
    chk("async_cpu_reset", cpu_reset, 1);
    chk("async_state", state_o, S_RST);
    chk("async_instr_count", instr_count, 0);
    repeat (3) @(negedge clk);
    sb.push_back(mk(S_HALT, 0, 0, 0, 0, 1));
    @(posedge clk);
    #1 reset_n = 1'b1;
    wait_idle(40);
    chk("final_state", state_o, S_HALT);
    chk("final_cpu_en", cpu_en, 0);
    chk("final_cpu_reset", cpu_reset, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Execution controller for the Hack `Computer` core on the DE0 board.
- Turns the raw push buttons into run, halt, single-step and CPU-reset commands.
- Drives the core's clock-enable and synchronous reset, halts on a PC breakpoint, and counts executed instructions for the 7-seg display path.
- Sits in the top level between the board I/O and the core; it only observes the core's debug outputs.

Parameters:
- DEBOUNCE_CYCLES, 500000, cycles a synchronized button level must stay stable before it is accepted (10 ms at 50 MHz).
- RESET_CYCLES, 4, number of cycles `cpu_reset` is held high after a reset command.
- PC_W, 15, width of the program counter and breakpoint address.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- btn_n  in  3  raw DE0 buttons, active-low, asynchronous. [0]=run/halt toggle, [1]=step, [2]=CPU reset.
- bp_en  in  1  breakpoint enable (static switch).
- bp_addr  in  PC_W  breakpoint PC (static switches, zero-extended by the top level).
- debug_pc  in  PC_W  current PC of the core.
- cpu_en  out  1  core clock-enable; the core advances one instruction per cycle in which this is high.
- cpu_reset  out  1  synchronous active-high reset to the core.
- state_o  out  2  current FSM state encoding, for the LEDs.
- bp_hit  out  1  sticky flag: the last halt was caused by the breakpoint.
- instr_count  out  16  instructions executed since the last CPU reset; wraps.

Behaviour:
- Reset (`reset_n` low, asynchronous):
  - state = RST; `cpu_reset` = 1; `cpu_en` = 0; `bp_hit` = 0; `instr_count` = 0.
  - Debouncer state is cleared to "released".
- Buttons:
  - Each button passes through a 2-flop synchronizer, then the debouncer.
  - A press produces a 1-cycle pulse on the debounced released->pressed transition only. Release produces nothing.
  - Holding a button produces exactly one pulse.
  - Priority when pulses coincide: reset > step > run.
- States (`state_o` encoding): RST=0, HALT=1, RUN=2, STEP=3.
- RST:
  - `cpu_reset` = 1, `cpu_en` = 0; a counter loads RESET_CYCLES.
  - After RESET_CYCLES cycles in RST, go to HALT.
  - `instr_count` is cleared on entry.
  - A reset pulse in any state enters RST and restarts the counter (including a reset pulse while already in RST).
- HALT:
  - `cpu_en` = 0.
  - run pulse -> RUN, and set `skip_bp` = 1.
  - step pulse -> STEP.
- RUN:
  - `cpu_en` = !(`bp_match` && !`skip_bp`), where `bp_match` = `bp_en` && (`debug_pc` == `bp_addr`). This is combinational, so a matching PC is never executed.
  - On a breakpoint: go to HALT and set `bp_hit` = 1.
  - run pulse -> HALT, with `cpu_en` = 0 in that same cycle.
  - `skip_bp` clears after the first cycle in RUN, so a resume from the breakpoint PC executes it once.
- STEP:
  - `cpu_en` = 1 for exactly one cycle, ignoring the breakpoint, then go to HALT.
- `bp_hit`:
  - Cleared on any run or step pulse and on RST.
  - Set only by a breakpoint halt.
- `instr_count`:
  - Increments by 1 (mod 2^16) on every cycle with `cpu_en` = 1.
  - 0xFFFF -> 0x0000 with no flag.
- `cpu_reset` = 1 only in RST.
- All outputs are registered except `cpu_en`, which is combinational from state, `skip_bp` and the compare.
- Changing `bp_addr` or `bp_en` while in RUN takes effect on the next cycle's compare. No glitch protection is required; the inputs are switches.
- Reset (`reset_n`) asserted mid-RUN: the core stops immediately; the RST sequence runs after `reset_n` releases.

Decomposition:
- Package `cpu_ctrl_pkg`:
  - `run_state_t` enum {RST, HALT, RUN, STEP} with the fixed encoding above.
  - Button index constants BTN_RUN=0, BTN_STEP=1, BTN_RST=2.
- Sub-module `btn_debounce`, instantiated 3 times:
  - Parameters: DEBOUNCE_CYCLES.
  - Ports: clk, reset_n, btn_n, press_pulse.
  - Contains the synchronizer, stability counter and edge detect.
- The benches use DEBOUNCE_CYCLES=4.

Test Plan:
- Reset release: `reset_n` 0->1 -> `cpu_reset` high for 4 cycles, then state=HALT, `cpu_en`=0, `instr_count`=0.
- Step: from HALT, press step for 10 cycles with 1-cycle bounce chatter -> exactly one `cpu_en` pulse, `instr_count`=1, state back to HALT.
- Breakpoint:
  - Setup: `bp_en`=1, `bp_addr`=0x0005; the model PC increments on `cpu_en`. Press run.
  - Expected: `cpu_en` high for 5 cycles (PC 0..4), low at PC 5; state=HALT; `bp_hit`=1; `instr_count`=5.
  - Press run again: PC 5 executes, `bp_hit`=0, RUN continues.
- Run/halt toggle: run press -> RUN; second run press -> HALT with `cpu_en` low in the pulse cycle. `instr_count` equals the number of cycles `cpu_en` was high.
- Priority: reset and run pulses in the same cycle -> RST wins, `instr_count` cleared.
- Wrap and async reset:
  - Preload `instr_count` to 0xFFFE, run 3 cycles -> 0x0001.
  - Drop `reset_n` mid-RUN -> `cpu_en`=0 in the same cycle, `cpu_reset`=1.
